// File: rtl/pix_frame_assembler_if.sv
//------------------------------------------------------------------------------
// Module   : pix_frame_assembler_if
// Purpose  : Byte input and framebuffer write/status bundle for the assembler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pix_frame_assembler_if #(
  parameter int ADDR_W = 15
);
  logic              i_byte_valid;
  logic [7:0]        i_byte_data;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [11:0]       o_wr_data;
  logic              o_frame_done;
  logic              o_err;
  logic              o_busy;

  modport master (
    output i_byte_valid, i_byte_data,
    input  o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_err, o_busy
  );

  modport slave (
    input  i_byte_valid, i_byte_data,
    output o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_err, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/pix_frame_assembler.sv
//------------------------------------------------------------------------------
// Module   : pix_frame_assembler
// Purpose  : Turns an AA 55 framed byte stream into RGB444 framebuffer writes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pix_frame_assembler #(
  parameter int H_ACT        = 160,
  parameter int V_ACT        = 120,
  parameter int ADDR_W       = 15,
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst,
  pix_frame_assembler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR2   = 2'd1,
    PIX_HI = 2'd2,
    PIX_LO = 2'd3
  } state_t;

  localparam int                c_to_w      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(H_ACT * V_ACT - 1);
  localparam logic [c_to_w-1:0] c_to_max    = c_to_w'(TIMEOUT_CLKS);
  localparam logic [c_to_w-1:0] c_to_fire   = c_to_w'(TIMEOUT_CLKS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_timeout;
  logic                w_hdr_ok;
  logic                w_red_ld;
  logic                w_pix_wr;

  logic [3:0]          r_red;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [c_to_w-1:0]   r_to_cnt;
  logic                r_wr_en;
  logic                r_last_wr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [11:0]         r_wr_data;
  logic                r_frame_done;
  logic                r_err;
  logic                r_busy;

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // The timeout fires on the edge where the idle count would reach TIMEOUT_CLKS
  // and takes priority over any byte strobed on that same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_hdr_ok    = 1'b0;
    w_red_ld    = 1'b0;
    w_pix_wr    = 1'b0;
    if (r_state != IDLE && r_to_cnt == c_to_fire) begin
      w_timeout   = 1'b1;
      w_state_nxt = IDLE;
    end else if (bus.i_byte_valid) begin
      case (r_state)
        IDLE:   if (bus.i_byte_data == 8'hAA) w_state_nxt = HDR2;
        HDR2: begin
          if (bus.i_byte_data == 8'h55) begin
            w_state_nxt = PIX_HI;
            w_hdr_ok    = 1'b1;
          end else if (bus.i_byte_data != 8'hAA) begin
            w_state_nxt = IDLE;
          end
        end
        PIX_HI: begin
          w_red_ld    = 1'b1;
          w_state_nxt = PIX_LO;
        end
        PIX_LO: begin
          w_pix_wr    = 1'b1;
          w_state_nxt = (r_pix_cnt == c_last_addr) ? IDLE : PIX_HI;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_red        <= 4'h0;
      r_pix_cnt    <= '0;
      r_to_cnt     <= '0;
      r_wr_en      <= 1'b0;
      r_last_wr    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 12'h000;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_wr_en      <= w_pix_wr;
      r_frame_done <= r_wr_en && r_last_wr;
      r_err        <= w_timeout;

      if (bus.i_byte_valid && !w_timeout)
        r_to_cnt <= '0;
      else if (r_state != IDLE && r_to_cnt != c_to_max)
        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_red_ld) r_red <= bus.i_byte_data[3:0];

      if (w_hdr_ok || w_timeout) r_pix_cnt <= '0;
      if (w_pix_wr) begin
        r_wr_addr <= r_pix_cnt;
        r_wr_data <= {r_red, bus.i_byte_data};
        r_pix_cnt <= r_pix_cnt + 1'b1;
        r_last_wr <= (r_pix_cnt == c_last_addr);
      end

      // A header accepted right at frame end re-arms busy over the done clear.
      if (w_timeout || (r_wr_en && r_last_wr)) r_busy <= 1'b0;
      if (w_hdr_ok)                            r_busy <= 1'b1;
    end
  end

  assign bus.o_wr_en      = r_wr_en;
  assign bus.o_wr_addr    = r_wr_addr;
  assign bus.o_wr_data    = r_wr_data;
  assign bus.o_frame_done = r_frame_done;
  assign bus.o_err        = r_err;
  assign bus.o_busy       = r_busy;

endmodule

`default_nettype wire
